// File: rtl/lut_func_unit.sv
// lut_func_unit: two-operand function c = f(a,b) via a runtime-loaded truth table.
// Optional LUT_FUNC_DEFAULT_TABLE_EN: reset into RUN holding the fixed 2-bit function.
module lut_func_unit #(
    parameter int W     = 2,
    parameter int OUT_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_first,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] c,
    output logic             tbl_valid,
    output logic             cfg_err,
    output logic [CNT_W-1:0] eval_cnt
);

    localparam int IDX_W = 2 * W;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        RUN
    } state_t;

`ifdef LUT_FUNC_DEFAULT_TABLE_EN
    localparam state_t RST_STATE = RUN;

    if (W != 2 || OUT_W != 2) begin : g_bad_cfg
        $fatal(1, "LUT_FUNC_DEFAULT_TABLE_EN needs W=2 and OUT_W=2");
    end

    // Fixed 2-bit function: p,q = a[1:0], r,s = b[1:0]
    function automatic logic [OUT_W-1:0] rst_entry(input int i);
        logic       p, q, r, s;
        logic [1:0] f;
        {p, q, r, s} = 4'(i);
        f[1] = (!p && r && s) || (!p && q && r) || (p && !r);
        f[0] = (p || q || s) && (q || r) && (!p || r);
        return OUT_W'(f);
    endfunction
`else
    localparam state_t RST_STATE = EMPTY;
`endif

    state_t           state;
    logic [IDX_W-1:0] load_idx;
    logic [OUT_W-1:0] tbl [DEPTH];

    logic             tbl_we;
    logic [IDX_W-1:0] wr_idx;
    logic             accept;

    assign cfg_ready = 1'b1;
    assign tbl_valid = (state == RUN);
    assign in_ready  = tbl_valid && !cfg_valid && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // A first beat always lands at entry 0; other beats only write while loading
    assign tbl_we = cfg_valid && (cfg_first || state == LOAD);
    assign wr_idx = cfg_first ? '0 : load_idx;

    // Load sequencer: tracks the fill index and flags stray beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            load_idx <= '0;
            cfg_err  <= 1'b0;
        end else if (cfg_valid) begin
            if (cfg_first) begin
                state    <= LOAD;
                load_idx <= IDX_W'(1);
                cfg_err  <= 1'b0;
            end else if (state == LOAD) begin
                if (load_idx == IDX_W'(DEPTH - 1)) begin
                    state    <= RUN;
                    load_idx <= '0;
                end else begin
                    load_idx <= load_idx + IDX_W'(1);
                end
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Truth-table storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef LUT_FUNC_DEFAULT_TABLE_EN
                tbl[i] <= rst_entry(i);
`else
                tbl[i] <= '0;
`endif
            end
        end else if (tbl_we) begin
            tbl[wr_idx] <= cfg_data;
        end
    end

    // Output register: lookup on accept, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            c         <= tbl[{a, b}];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Completed output handshakes, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt <= '0;
        end else if (out_valid && out_ready) begin
            eval_cnt <= eval_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_lut_func_unit.sv
// tb_lut_func_unit: scenario tasks with a result scoreboard for lut_func_unit.
// Expected results are queued on input handshake and popped on output handshake.
module tb_lut_func_unit;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_first;
    logic [1:0]  cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  c;
    logic        tbl_valid;
    logic        cfg_err;
    logic [15:0] eval_cnt;

`ifdef LUT_FUNC_DEFAULT_TABLE_EN
    localparam logic TV0 = 1'b1;
`else
    localparam logic TV0 = 1'b0;
`endif

    logic [1:0] func_t [16] = '{0, 0, 0, 3, 1, 1, 3, 3, 2, 2, 1, 1, 2, 2, 1, 1};
    logic [1:0] mdl [16];
    logic [1:0] exp_q [$];
    logic [15:0] exp_cnt;
    int passed;
    int total;

    lut_func_unit #(.W(2), .OUT_W(2), .CNT_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_first(cfg_first),
        .cfg_data(cfg_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c(c),
        .tbl_valid(tbl_valid),
        .cfg_err(cfg_err),
        .eval_cnt(eval_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard push: an input handshake completes at the next rising edge
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) exp_q.push_back(mdl[{a, b}]);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset;
        #3;
        total++;
        if (tbl_valid !== TV0) $display("FAIL rst_tbl_valid: got %b want %b", tbl_valid, TV0);
        else passed++;
        total++;
        if (in_ready !== TV0) $display("FAIL rst_in_ready: got %b want %b", in_ready, TV0);
        else passed++;
        total++;
        if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || c !== 2'd0) $display("FAIL rst_out: out_valid=%b c=%0d want 0 0", out_valid, c);
        else passed++;
        total++;
        if (eval_cnt !== 16'd0 || cfg_err !== 1'b0) $display("FAIL rst_cnt_err: eval_cnt=%0d cfg_err=%b want 0 0", eval_cnt, cfg_err);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (tbl_valid !== TV0) $display("FAIL rst_release_tv: got %b want %b", tbl_valid, TV0);
        else passed++;
    endtask

    task automatic test_load;
        logic [1:0] e;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i == 15) begin
                total++;
                if (tbl_valid !== 1'b0) $display("FAIL load_tv_early: got %b want 0", tbl_valid);
                else passed++;
            end
            cfg_valid = 1'b1;
            cfg_first = (i == 0);
            cfg_data  = 2'(i % 4);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = 2'(i % 4);
        total++;
        if (tbl_valid !== 1'b1 || cfg_err !== 1'b0) $display("FAIL load_done: tbl_valid=%b cfg_err=%b want 1 0", tbl_valid, cfg_err);
        else passed++;
        in_valid = 1'b1;
        a = 2'd2;
        b = 2'd3;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL load_in_ready: got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || c !== 2'd3) $display("FAIL load_eval: out_valid=%b c=%0d want 1 3", out_valid, c);
        else passed++;
        total++;
        if (!(out_valid && out_ready) || exp_q.size() == 0) $display("FAIL load_sb: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (c !== e) $display("FAIL load_sb: c=%0d want %0d", c, e);
            else passed++;
        end
        exp_cnt = exp_cnt + 16'd1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || eval_cnt !== exp_cnt) $display("FAIL load_drain: out_valid=%b eval_cnt=%0d want 0 %0d", out_valid, eval_cnt, exp_cnt);
        else passed++;
    endtask

    task automatic test_sweep;
        logic [1:0] e;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            cfg_valid = 1'b1;
            cfg_first = (i == 0);
            cfg_data  = func_t[i];
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = func_t[i];
        exp_cnt = exp_cnt + 16'd16;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 16);
            {a, b} = 4'(k);
            @(negedge clk);
            if (k < 16) begin
                total++;
                if (in_ready !== 1'b1) $display("FAIL sweep_in_ready%0d: got %b want 1", k, in_ready);
                else passed++;
            end
            if (k >= 1 && k <= 16) begin
                total++;
                if (!(out_valid && out_ready) || exp_q.size() == 0) $display("FAIL sweep_out%0d: out_valid=%b queued=%0d", k - 1, out_valid, exp_q.size());
                else begin
                    e = exp_q.pop_front();
                    if (c !== e) $display("FAIL sweep_out%0d: c=%0d want %0d", k - 1, c, e);
                    else passed++;
                end
            end
            if (k == 17) begin
                total++;
                if (out_valid !== 1'b0 || eval_cnt !== exp_cnt) $display("FAIL sweep_end: out_valid=%b eval_cnt=%0d want 0 %0d", out_valid, eval_cnt, exp_cnt);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] e;
        logic [15:0] cnt0;
        cnt0 = exp_cnt;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 2'd1;
        b = 2'd2;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_first_ready: got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        a = 2'd3;
        b = 2'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || c !== mdl[6]) $display("FAIL bp_hold%0d: out_valid=%b c=%0d want 1 %0d", k, out_valid, c, mdl[6]);
            else passed++;
            total++;
            if (in_ready !== 1'b0) $display("FAIL bp_stall%0d: in_ready=%b want 0", k, in_ready);
            else passed++;
            total++;
            if (eval_cnt !== cnt0) $display("FAIL bp_cnt%0d: eval_cnt=%0d want %0d", k, eval_cnt, cnt0);
            else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (!(out_valid && out_ready) || exp_q.size() == 0) $display("FAIL bp_out0: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (c !== e) $display("FAIL bp_out0: c=%0d want %0d", c, e);
            else passed++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (!(out_valid && out_ready) || exp_q.size() == 0) $display("FAIL bp_out1: out_valid=%b queued=%0d", out_valid, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if (c !== e) $display("FAIL bp_out1: c=%0d want %0d", c, e);
            else passed++;
        end
        @(posedge clk); #1;
        exp_cnt = cnt0 + 16'd2;
        total++;
        if (out_valid !== 1'b0 || eval_cnt !== exp_cnt) $display("FAIL bp_end: out_valid=%b eval_cnt=%0d want 0 %0d", out_valid, eval_cnt, exp_cnt);
        else passed++;
    endtask

    task automatic test_stray;
        logic [1:0] e;
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_first = 1'b0;
        cfg_data  = 2'd3;
        in_valid  = 1'b1;
        a = 2'd0;
        b = 2'd0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) $display("FAIL stray_prio: in_ready=%b want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (cfg_err !== 1'b1 || tbl_valid !== 1'b1) $display("FAIL stray_err: cfg_err=%b tbl_valid=%b want 1 1", cfg_err, tbl_valid);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 2);
            {a, b} = (k == 0) ? 4'd0 : 4'd8;
            @(negedge clk);
            if (k >= 1) begin
                total++;
                if (!(out_valid && out_ready) || exp_q.size() == 0) $display("FAIL stray_look%0d: out_valid=%b queued=%0d", k, out_valid, exp_q.size());
                else begin
                    e = exp_q.pop_front();
                    if (c !== e) $display("FAIL stray_look%0d: c=%0d want %0d", k, c, e);
                    else passed++;
                end
            end
        end
        exp_cnt = exp_cnt + 16'd2;
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_first = 1'b1;
        cfg_data  = 2'd2;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        total++;
        if (cfg_err !== 1'b0 || tbl_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL stray_clear: cfg_err=%b tbl_valid=%b in_ready=%b want 0 0 0", cfg_err, tbl_valid, in_ready);
        else passed++;
    endtask

    task automatic test_restart;
        logic [1:0] e;
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            if (i == 6 || i == 20) begin
                total++;
                if (tbl_valid !== 1'b0) $display("FAIL restart_tv%0d: got %b want 0", i, tbl_valid);
                else passed++;
            end
            cfg_valid = 1'b1;
            cfg_first = (i == 0 || i == 5);
            cfg_data  = (i < 5) ? 2'd2 : (i == 5) ? 2'd1 : 2'((i - 5) % 4);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        mdl[0] = 2'd1;
        for (int i = 1; i < 16; i++) mdl[i] = 2'(i % 4);
        total++;
        if (tbl_valid !== 1'b1) $display("FAIL restart_done: tbl_valid=%b want 1", tbl_valid);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            in_valid = (k < 3);
            {a, b} = (k == 0) ? 4'd0 : (k == 1) ? 4'd5 : 4'd15;
            @(negedge clk);
            if (k >= 1) begin
                total++;
                if (!(out_valid && out_ready) || exp_q.size() == 0) $display("FAIL restart_look%0d: out_valid=%b queued=%0d", k, out_valid, exp_q.size());
                else begin
                    e = exp_q.pop_front();
                    if (c !== e) $display("FAIL restart_look%0d: c=%0d want %0d", k, c, e);
                    else passed++;
                end
            end
        end
        exp_cnt = exp_cnt + 16'd3;
        @(posedge clk); #1;
        total++;
        if (eval_cnt !== exp_cnt) $display("FAIL restart_cnt: eval_cnt=%0d want %0d", eval_cnt, exp_cnt);
        else passed++;
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 2'd1;
        b = 2'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) $display("FAIL ar_pending: out_valid=%b want 1", out_valid);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1;
            cfg_first = (i == 0);
            cfg_data  = 2'd3;
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || c !== 2'd0) $display("FAIL ar_out: out_valid=%b c=%0d want 0 0", out_valid, c);
        else passed++;
        total++;
        if (eval_cnt !== 16'd0 || cfg_err !== 1'b0) $display("FAIL ar_cnt: eval_cnt=%0d cfg_err=%b want 0 0", eval_cnt, cfg_err);
        else passed++;
        total++;
        if (tbl_valid !== TV0) $display("FAIL ar_tv: tbl_valid=%b want %b", tbl_valid, TV0);
        else passed++;
        cfg_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        exp_cnt = 16'd0;
        for (int i = 0; i < 16; i++) mdl[i] = TV0 ? func_t[i] : 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (tbl_valid !== TV0 || eval_cnt !== 16'd0) $display("FAIL ar_after: tbl_valid=%b eval_cnt=%0d want %b 0", tbl_valid, eval_cnt, TV0);
        else passed++;
`ifdef LUT_FUNC_DEFAULT_TABLE_EN
        in_valid = 1'b1;
        a = 2'd0;
        b = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || c !== func_t[1]) $display("FAIL ar_default: out_valid=%b c=%0d want 1 %0d", out_valid, c, func_t[1]);
        else passed++;
        void'(exp_q.pop_front());
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        exp_cnt   = 16'd0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_first = 1'b0;
        cfg_data  = 2'd0;
        in_valid  = 1'b0;
        a         = 2'd0;
        b         = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = TV0 ? func_t[i] : 2'd0;
        test_reset;
        test_load;
        test_sweep;
        test_backpressure;
        test_stray;
        test_restart;
        test_async_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
